// File: rtl/trial_div_scanner.sv
// Trial-division scanner: walks the 8 candidate divisors presented by the upstream
// mux and divides a latched dividend by each with a bit-serial restoring divider.
module trial_div_scanner #(
   parameter int SIZE = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [SIZE-1:0] n_in,
   input  logic [SIZE-1:0] mux_y,
   output logic [2:0]      in_mux_add,
   output logic            busy,
   output logic            done,
   output logic [7:0]      hit_mask,
   output logic            found,
   output logic [SIZE-1:0] first_factor,
   output logic [SIZE-1:0] first_quot
);

   localparam int CW = $clog2(SIZE + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(SIZE);
   localparam logic [CW-1:0] CNT_LAST = CW'(1);
   localparam logic [SIZE-1:0] ONE = SIZE'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_DIV,
      S_CHECK,
      S_NEXT,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [SIZE-1:0] n_q;
   logic [SIZE-1:0] d_q;
   logic [SIZE-1:0] q_q;
   logic [SIZE-1:0] r_q;
   logic [CW-1:0]   bit_cnt;
   logic [2:0]      idx;

   logic [SIZE:0]   trial;
   logic [SIZE-1:0] diff;
   logic            fits;
   logic            skip;

   // One restoring step: the remainder is always < D, so the difference fits in SIZE bits.
   always_comb begin
      trial = {r_q, q_q[SIZE-1]};
      fits  = (trial >= {1'b0, d_q});
      diff  = trial[SIZE-1:0] - d_q;
      skip  = (mux_y <= ONE);
   end

   assign in_mux_add = idx;

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start) state_nxt = S_LATCH;
         S_LATCH: state_nxt = skip ? S_NEXT : S_DIV;
         S_DIV:   if (bit_cnt == CNT_LAST) state_nxt = S_CHECK;
         S_CHECK: state_nxt = S_NEXT;
         S_NEXT:  state_nxt = (idx == 3'd7) ? S_DONE : S_LATCH;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic: decoded from the state register so reset clears it immediately.
   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q          <= '0;
         d_q          <= '0;
         q_q          <= '0;
         r_q          <= '0;
         bit_cnt      <= '0;
         idx          <= '0;
         hit_mask     <= '0;
         found        <= 1'b0;
         first_factor <= '0;
         first_quot   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  n_q          <= n_in;
                  idx          <= '0;
                  hit_mask     <= '0;
                  found        <= 1'b0;
                  first_factor <= '0;
                  first_quot   <= '0;
               end
            end
            S_LATCH: begin
               d_q <= mux_y;
               if (!skip) begin
                  r_q     <= '0;
                  q_q     <= n_q;
                  bit_cnt <= CNT_INIT;
               end
            end
            S_DIV: begin
               r_q     <= fits ? diff : trial[SIZE-1:0];
               q_q     <= {q_q[SIZE-2:0], fits};
               bit_cnt <= bit_cnt - CNT_LAST;
            end
            S_CHECK: begin
               if (r_q == '0) begin
                  hit_mask[idx] <= 1'b1;
                  if (!found) begin
                     found        <= 1'b1;
                     first_factor <= d_q;
                     first_quot   <= q_q;
                  end
               end
            end
            S_NEXT: begin
               if (idx != 3'd7) idx <= idx + 3'd1;
            end
            S_DONE: ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_trial_div_scanner.sv
// Bench for trial_div_scanner: models the 8:1 candidate mux and checks each scan
// against a plain-arithmetic model of trial division and scan latency.
module tb_trial_div_scanner;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] n_in = '0;
   logic [7:0] mux_y;
   logic [2:0] in_mux_add;
   logic       busy, done, found;
   logic [7:0] hit_mask, first_factor, first_quot;

   logic [7:0] cand [8];
   int n_pass = 0;
   int n_total = 0;

   trial_div_scanner #(.SIZE(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .mux_y(mux_y),
      .in_mux_add(in_mux_add), .busy(busy), .done(done), .hit_mask(hit_mask),
      .found(found), .first_factor(first_factor), .first_quot(first_quot)
   );

   always #5 clk = ~clk;

   assign mux_y = cand[in_mux_add];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_cands(input int c0, c1, c2, c3, c4, c5, c6, c7);
      cand[0] = 8'(c0); cand[1] = 8'(c1); cand[2] = 8'(c2); cand[3] = 8'(c3);
      cand[4] = 8'(c4); cand[5] = 8'(c5); cand[6] = 8'(c6); cand[7] = 8'(c7);
   endtask

   // Runs one full scan of dividend n over cand[]; if repulse_at > 0, start is
   // re-asserted with a different n_in around that cycle of the scan.
   task automatic run_scan(input logic [7:0] n, input int repulse_at);
      int exp_mask = 0, exp_found = 0, exp_ff = 0, exp_fq = 0, exp_lat = 1;
      int cyc = 0, done_cyc = 0, prev_sel = 0;
      int nv = int'(n);
      bit step_ok = 1'b1;

      for (int i = 0; i < 8; i++) begin
         int c = int'(cand[i]);
         if (c < 2) exp_lat += 2;
         else begin
            exp_lat += 11;
            if (nv % c == 0) begin
               exp_mask |= (1 << i);
               if (exp_found == 0) begin
                  exp_found = 1;
                  exp_ff = c;
                  exp_fq = nv / c;
               end
            end
         end
      end

      @(negedge clk);
      n_in  = n;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (done_cyc == 0 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) step_ok &= (in_mux_add == 3'd0);
         else step_ok &= (int'(in_mux_add) == prev_sel || int'(in_mux_add) == prev_sel + 1);
         prev_sel = int'(in_mux_add);
         if (repulse_at > 0 && cyc == repulse_at) begin
            start = 1'b1;
            n_in  = ~n;
         end
         if (repulse_at > 0 && cyc == repulse_at + 1) start = 1'b0;
         if (done) done_cyc = cyc;
      end
      if (done_cyc == 0) begin
         check("done_timeout", 0, 1);
         return;
      end
      // start during the DONE cycle must be ignored
      start = 1'b1;
      check("latency", done_cyc, exp_lat);
      check("hit_mask", hit_mask, exp_mask);
      check("found", found, exp_found);
      check("first_factor", first_factor, exp_ff);
      check("first_quot", first_quot, exp_fq);
      check("sel_steps", step_ok, 1);
      check("sel_final", in_mux_add, 7);
      @(negedge clk);
      start = 1'b0;
      check("done_pulse", done, 0);
      check("busy_after", busy, 0);
      check("hold_mask", hit_mask, exp_mask);
   endtask

   initial begin
      set_cands(0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_mask", hit_mask, 0);
      check("rst_sel", in_mux_add, 0);
      @(negedge clk) rst_n = 1'b1;

      set_cands(2, 3, 4, 5, 6, 7, 0, 1);
      run_scan(8'd30, 0);
      set_cands(2, 3, 4, 5, 6, 7, 8, 9);
      run_scan(8'd97, 0);
      set_cands(255, 17, 15, 5, 3, 2, 254, 128);
      run_scan(8'd255, 0);
      set_cands(200, 5, 1, 1, 1, 1, 1, 1);
      run_scan(8'd5, 0);
      set_cands(3, 3, 3, 3, 3, 3, 3, 3);
      run_scan(8'd0, 0);

      // start re-pulsed mid-division must not disturb the running scan
      set_cands(2, 3, 4, 5, 6, 7, 0, 1);
      run_scan(8'd30, 5);

      // asynchronous reset during the division of index 3
      set_cands(2, 3, 4, 5, 6, 7, 8, 9);
      @(negedge clk);
      n_in  = 8'd30;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (38) @(negedge clk);
      check("mid_sel", in_mux_add, 3);
      check("mid_mask", hit_mask, 8'h03);
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_mask", hit_mask, 0);
      check("arst_found", found, 0);
      check("arst_ff", first_factor, 0);
      check("arst_fq", first_quot, 0);
      check("arst_sel", in_mux_add, 0);
      @(negedge clk) rst_n = 1'b1;
      run_scan(8'd30, 0);

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 8; i++)
            cand[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 1))
                                                   : 8'($urandom_range(2, 20));
         run_scan(8'($urandom_range(0, 255)), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
